imem_loader: RTL

Boot-time program loader that is the write side of the instruction memory: the MIPS core only fetches from instruction memory, and this block fills it from a byte stream before the core runs. It accepts bytes over a valid/ready handshake, assembles big-endian 32-bit words, and issues one write per word at PC-style byte addresses. It holds the core in reset until the image is complete.

---
 rtl/imem_loader_pkg.sv | 28 ++
 rtl/imem_loader_if.sv | 39 +++
 rtl/imem_loader_byte_word_assembler.sv | 44 ++++
 rtl/imem_loader.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg
//   Shared definitions for the instruction-memory boot loader:
//   loader state encoding, frame geometry constants and the
//   word-index to byte-address helper.
//   Optional feature macro used by the loader: IMEM_LOADER_CHECKSUM_EN.
package imem_loader_pkg;

    localparam int unsigned HDR_BYTES       = 2;
    localparam int unsigned BYTES_PER_WORD  = 4;
    localparam int unsigned WORD_BYTES_LOG2 = 2;

    typedef enum logic [2:0] {
        HDR_HI,
        HDR_LO,
        DATA,
        CHECK,
        FIN,
        DONE,
        ERR
    } state_t;

    // Byte address of word idx, counted from base.
    function automatic logic [31:0] word_addr(input logic [31:0] base,
                                              input logic [15:0] idx);
        return base + ({16'd0, idx} << WORD_BYTES_LOG2);
    endfunction

endpackage

// File: rtl/imem_loader_if.sv
// imem_loader_if
//   Byte-stream input handshake and instruction-memory write bus of the
//   boot loader.
//   Signals:
//     in_valid  stream byte present
//     in_ready  loader can accept a byte
//     in_byte   stream byte
//     wr_en     one-cycle instruction-memory write strobe
//     wr_addr   word-aligned write byte address
//     wr_data   write word
//   Modports:
//     slave   the loader (consumes the stream, drives the write bus)
//     master  the host side (drives the stream, observes the write bus)
interface imem_loader_if;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_byte;
    logic        wr_en;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;

    modport slave (
        input  in_valid,
        input  in_byte,
        output in_ready,
        output wr_en,
        output wr_addr,
        output wr_data
    );

    modport master (
        output in_valid,
        output in_byte,
        input  in_ready,
        input  wr_en,
        input  wr_addr,
        input  wr_data
    );
endinterface

// File: rtl/imem_loader_byte_word_assembler.sv
// imem_loader_byte_word_assembler (the loader's byte_word_assembler)
//   Collects stream bytes MSB first into 32-bit words. A byte counter
//   wraps after the fourth byte; on that byte o_word_valid pulses
//   (combinationally, in the accepting cycle) with the completed word.
//   Ports:
//     clock         system clock
//     reset         synchronous active-high reset
//     i_clear       synchronous clear (new load requested)
//     i_byte_valid  a data byte is transferred this cycle
//     i_byte        data byte
//     o_word_valid  this byte completes a word
//     o_word        completed word (valid with o_word_valid)
module imem_loader_byte_word_assembler (
    input  logic        clock,
    input  logic        reset,
    input  logic        i_clear,
    input  logic        i_byte_valid,
    input  logic [7:0]  i_byte,
    output logic        o_word_valid,
    output logic [31:0] o_word
);
    import imem_loader_pkg::*;

    localparam int unsigned SHIFT_BITS = 8 * (BYTES_PER_WORD - 1);

    logic [WORD_BYTES_LOG2-1:0] r_byte_cnt;
    logic [SHIFT_BITS-1:0]      r_shift;

    always_ff @(posedge clock) begin
        if (reset || i_clear) begin
            r_byte_cnt <= '0;
            r_shift    <= '0;
        end else if (i_byte_valid) begin
            r_shift    <= {r_shift[SHIFT_BITS-9:0], i_byte};
            r_byte_cnt <= r_byte_cnt + 1'b1;
        end
    end

    // Only the three leading bytes are stored; the fourth is taken
    // straight from the input so the word is ready in its own cycle.
    assign o_word_valid = i_byte_valid && (&r_byte_cnt);
    assign o_word       = {r_shift, i_byte};

endmodule

// File: rtl/imem_loader.sv
// imem_loader
//   Boot-time write side of the instruction memory. Receives a frame
//   (16-bit word count N MSB first, N big-endian words, optional
//   checksum byte) over a valid/ready byte stream and writes each word
//   at ADDR_BASE + 4*index. Holds the core in reset until the image is
//   complete.
//   Optional feature: define IMEM_LOADER_CHECKSUM_EN to require a
//   trailing XOR checksum byte over all header and data bytes.
//   Parameters:
//     ADDR_BASE  byte address of the first word
//     MAX_WORDS  largest accepted word count
//   Ports:
//     clock      system clock
//     reset      synchronous active-high reset
//     reload     request a new load (honoured in DONE / ERR only)
//     bus        stream handshake + memory write bus (slave modport)
//     cpu_reset  core reset, high except in DONE
//     done       image loaded (level)
//     error      load aborted (level)
module imem_loader #(
    parameter logic [31:0] ADDR_BASE = 32'h0000_0000,
    parameter int unsigned MAX_WORDS = 256
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         reload,
    imem_loader_if.slave bus,
    output logic         cpu_reset,
    output logic         done,
    output logic         error
);
    import imem_loader_pkg::*;

`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam state_t AFTER_DATA = CHECK;
`else
    localparam state_t AFTER_DATA = FIN;
`endif

    state_t      r_state;
    state_t      w_next;

    logic        w_ready;
    logic        w_accept;
    logic        w_reload_take;
    logic        w_last_word;
    logic [15:0] w_n;

    logic [15:0] r_count;
    logic [15:0] r_word_idx;
    logic        r_wr_en;
    logic [31:0] r_wr_addr;
    logic [31:0] r_wr_data;

    logic        w_word_valid;
    logic [31:0] w_word;

`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]  r_csum;
`endif

    assign w_ready = (r_state == HDR_HI) || (r_state == HDR_LO) ||
                     (r_state == DATA)   || (r_state == CHECK);
    assign w_accept      = bus.in_valid && w_ready;
    assign w_reload_take = reload && ((r_state == DONE) || (r_state == ERR));
    // Full count as seen while the low header byte is on the bus.
    assign w_n           = {r_count[15:8], bus.in_byte};
    assign w_last_word   = (r_word_idx == (r_count - 16'd1));

    imem_loader_byte_word_assembler u_byte_word_assembler (
        .clock        (clock),
        .reset        (reset),
        .i_clear      (w_reload_take),
        .i_byte_valid (w_accept && (r_state == DATA)),
        .i_byte       (bus.in_byte),
        .o_word_valid (w_word_valid),
        .o_word       (w_word)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= HDR_HI;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            HDR_HI: begin
                if (w_accept) begin
                    w_next = HDR_LO;
                end
            end
            HDR_LO: begin
                if (w_accept) begin
                    if (32'(w_n) > MAX_WORDS) begin
                        w_next = ERR;
                    end else if (w_n == 16'd0) begin
                        w_next = AFTER_DATA;
                    end else begin
                        w_next = DATA;
                    end
                end
            end
            DATA: begin
                if (w_word_valid && w_last_word) begin
                    w_next = AFTER_DATA;
                end
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            CHECK: begin
                if (w_accept) begin
                    w_next = (bus.in_byte == r_csum) ? FIN : ERR;
                end
            end
`endif
            FIN: begin
                w_next = DONE;
            end
            DONE, ERR: begin
                if (reload) begin
                    w_next = HDR_HI;
                end
            end
            default: begin
                w_next = HDR_HI;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_count    <= '0;
            r_word_idx <= '0;
            r_wr_en    <= 1'b0;
            r_wr_addr  <= ADDR_BASE;
            r_wr_data  <= '0;
        end else begin
            r_wr_en <= 1'b0;
            if (w_reload_take) begin
                r_word_idx <= '0;
            end
            if (w_accept && (r_state == HDR_HI)) begin
                r_count <= {bus.in_byte, 8'h00};
            end
            if (w_accept && (r_state == HDR_LO)) begin
                r_count <= w_n;
            end
            if (w_word_valid) begin
                r_wr_en    <= 1'b1;
                r_wr_addr  <= word_addr(ADDR_BASE, r_word_idx);
                r_wr_data  <= w_word;
                r_word_idx <= r_word_idx + 16'd1;
            end
        end
    end

`ifdef IMEM_LOADER_CHECKSUM_EN
    always_ff @(posedge clock) begin
        if (reset || w_reload_take) begin
            r_csum <= '0;
        end else if (w_accept && (r_state != CHECK)) begin
            r_csum <= r_csum ^ bus.in_byte;
        end
    end
`endif

    assign bus.in_ready = w_ready;
    assign bus.wr_en    = r_wr_en;
    assign bus.wr_addr  = r_wr_addr;
    assign bus.wr_data  = r_wr_data;

    assign done      = (r_state == DONE);
    assign error     = (r_state == ERR);
    assign cpu_reset = (r_state != DONE);

endmodule
